sync_fifo: RTL and testbench
============================

# sync_fifo

Single-clock, parametrised FIFO for intra-domain buffering in the reader datapath, such as between the demodulator symbol stage and the frame decoder. It generalises the team's async FIFO to one clock domain and adds an occupancy count, programmable almost-full/almost-empty thresholds, and one-cycle overflow/underflow error pulses. A compile-time option selects first-word-fall-through or standard read timing.

## Interface
- ADDR_WIDTH, 3: log2 of depth; DEPTH = 2**ADDR_WIDTH entries
- DATA_WIDTH, 24: word width
- AFULL_THRESH, 2**ADDR_WIDTH-1: almost_full asserts when count >= this; legal range 1..DEPTH
- AEMPTY_THRESH, 1: almost_empty asserts when count <= this; legal range 0..DEPTH-1
- clk  in  1  sole clock, rising edge
- rst  in  1  asynchronous, active-high reset
- wr_en  in  1  write request
- wr_data  in  DATA_WIDTH  write word
- rd_en  in  1  read request (pop acknowledge in FWFT mode)
- rd_data  out  DATA_WIDTH  read word
- rd_empty  out  1  no words stored
- wr_full  out  1  DEPTH words stored
- almost_full  out  1  count >= AFULL_THRESH
- almost_empty  out  1  count <= AEMPTY_THRESH
- count  out  ADDR_WIDTH+1  words stored, 0..DEPTH
- overflow  out  1  one-cycle pulse: write rejected because full
- underflow  out  1  one-cycle pulse: read rejected because empty

## Operation
- Write acceptance: wr_acc = wr_en && !wr_full. On acceptance, wr_data is stored at wr_ptr and wr_ptr increments.
- Read acceptance: rd_acc = rd_en && !rd_empty. On acceptance, rd_ptr increments.
- wr_ptr and rd_ptr are ADDR_WIDTH bits wide and wrap modulo DEPTH with no special case.
- count_next = count + wr_acc - rd_acc. This is computed at ADDR_WIDTH+1 bits and never exceeds DEPTH or drops below 0.
- All status flags are registered. Each is decoded from count_next, so it exactly matches count in the same cycle:
  - rd_empty = (count == 0)
  - wr_full = (count == DEPTH)
  - almost_full = (count >= AFULL_THRESH)
  - almost_empty = (count <= AEMPTY_THRESH)
- Both requests while full: the read is accepted and the write is rejected. overflow pulses and count becomes DEPTH-1.
- Both requests while empty: the write is accepted and the read is rejected. underflow pulses and count becomes 1.
- Both requests with 0 < count < DEPTH: both are accepted and count is unchanged.
- overflow is registered wr_en && wr_full. underflow is registered rd_en && rd_empty. Each is high for exactly one cycle per rejected request.
- Storage is not reset. Its contents are undefined after reset and are never observable, because rd_empty masks them.

## Timing
- Reset values: count 0, rd_empty 1, wr_full 0, almost_empty 1, almost_full 0, overflow 0, underflow 0, rd_data 0. Both pointers reset to 0.
- Reset asserted mid-operation discards all contents immediately. The first write after rst deasserts is accepted normally.
- Flag latency: flags and count update on the same edge that accepts the request.
  - A write into an empty FIFO clears rd_empty on that edge, so rd_empty is low in the next cycle.
  - A write that reaches DEPTH sets wr_full on that edge.
- Standard mode: rd_data is registered.
  - It updates on the edge that accepts a read and shows mem[rd_ptr] as it was before that edge.
  - It holds otherwise.
  - Read latency is 1 cycle.
- FWFT mode: see Configuration.
- Throughput: one write and one read per cycle, sustained indefinitely, with no bubble at pointer wrap.

## Configuration
- Macro: SYNC_FIFO_FWFT_EN.
- Defined (first-word-fall-through):
  - Whenever rd_empty is 0, rd_data presents the head word.
  - rd_en acknowledges consumption. The next word is visible in the cycle after the acknowledging edge.
  - On a write into an empty FIFO, the word appears on rd_data in the same cycle rd_empty deasserts.
  - While rd_empty is 1, rd_data holds its last value (0 after reset).
- Undefined (standard mode): registered read as described under Timing.
- Interface, flags, count and error pulses are identical in both modes.

## Test plan
- Reset with defaults, then idle: rd_empty=1, almost_empty=1, count=0, wr_full=0, rd_data=0.
- Write 0x000001..0x000008 on consecutive cycles:
  - count steps 1..8.
  - almost_empty drops when count reaches 2.
  - almost_full rises at 7; wr_full rises at 8.
  - A ninth write pulses overflow for 1 cycle and leaves count=8.
- Drain the FIFO from full with rd_en held:
  - Data reads 0x000001..0x000008 in order; standard mode gives 1-cycle latency, FWFT mode presents data directly.
  - rd_empty=1 after the 8th pop.
  - A further rd_en pulses underflow and leaves count=0.
- With count=4, drive wr_en and rd_en for 20 cycles using incrementing data:
  - count stays 4 throughout.
  - Data order is preserved across two pointer wraps.
- Boundary cases:
  - Full plus simultaneous wr_en and rd_en gives count=7 with overflow=1.
  - Empty plus simultaneous requests gives count=1 with underflow=1, and the written word is read back next.
- Assert rst with count=5 for a partial cycle: all outputs return to reset values immediately; a subsequent write/read of 0xABCDEF returns 0xABCDEF.

Source files
------------

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count, programmable almost-full/almost-empty
// thresholds and overflow/underflow pulses. Define SYNC_FIFO_FWFT_EN for first-word-fall-through reads.
module sync_fifo #(
  parameter int ADDR_WIDTH    = 3,
  parameter int DATA_WIDTH    = 24,
  parameter int AFULL_THRESH  = 2**ADDR_WIDTH - 1,
  parameter int AEMPTY_THRESH = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_empty,
  output logic                  wr_full,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int CW = ADDR_WIDTH + 1;
  localparam int DEPTH = 2**ADDR_WIDTH;
  localparam logic [CW-1:0] DEPTH_C  = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [CW-1:0] AFULL_C  = AFULL_THRESH[CW-1:0];
  localparam logic [CW-1:0] AEMPTY_C = AEMPTY_THRESH[CW-1:0];

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  rd_empty_q, wr_full_q, almost_full_q, almost_empty_q;
  logic                  overflow_q, underflow_q;
  logic [DATA_WIDTH-1:0] rd_data_q;
  logic                  wr_acc, rd_acc;

  assign wr_acc   = wr_en && !wr_full_q;
  assign rd_acc   = rd_en && !rd_empty_q;
  assign wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(wr_acc);
  assign rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(rd_acc);
  assign count_d  = count_q + CW'(wr_acc) - CW'(rd_acc);

  // Storage carries no reset; rd_empty keeps stale contents unobservable.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[wr_ptr_q] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      rd_empty_q     <= 1'b1;
      wr_full_q      <= 1'b0;
      almost_full_q  <= 1'b0;
      almost_empty_q <= 1'b1;
      overflow_q     <= 1'b0;
      underflow_q    <= 1'b0;
    end else begin
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
      rd_empty_q     <= (count_d == '0);
      wr_full_q      <= (count_d == DEPTH_C);
      almost_full_q  <= (count_d >= AFULL_C);
      almost_empty_q <= (count_d <= AEMPTY_C);
      overflow_q     <= wr_en && wr_full_q;
      underflow_q    <= rd_en && rd_empty_q;
    end
  end

`ifdef SYNC_FIFO_FWFT_EN
  logic [DATA_WIDTH-1:0] head_d;

  // A write landing at the new head slot must bypass the array, as mem is not yet updated.
  always_comb begin
    head_d = rd_data_q;
    if (count_d != '0) begin
      if (wr_acc && (wr_ptr_q == rd_ptr_d)) begin
        head_d = wr_data;
      end else begin
        head_d = mem[rd_ptr_d];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= head_d;
    end
  end
`else
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data_q <= '0;
    end else if (rd_acc) begin
      rd_data_q <= mem[rd_ptr_q];
    end
  end
`endif

  assign rd_data      = rd_data_q;
  assign rd_empty     = rd_empty_q;
  assign wr_full      = wr_full_q;
  assign almost_full  = almost_full_q;
  assign almost_empty = almost_empty_q;
  assign count        = count_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

endmodule

// File: tb/tb_sync_fifo.sv
// Directed self-checking bench for sync_fifo with default parameters
// (depth 8, 24-bit words, almost_full at 7, almost_empty at 1).
module tb_sync_fifo;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en;
  logic [23:0] wr_data;
  logic        rd_en;
  logic [23:0] rd_data;
  logic        rd_empty, wr_full, almost_full, almost_empty;
  logic [3:0]  count;
  logic        overflow, underflow;

  int checks = 0;
  int errors = 0;

  sync_fifo dut (
    .clk          (clk),
    .rst          (rst),
    .wr_en        (wr_en),
    .wr_data      (wr_data),
    .rd_en        (rd_en),
    .rd_data      (rd_data),
    .rd_empty     (rd_empty),
    .wr_full      (wr_full),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .count        (count),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge; outputs are sampled 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, ".count"}, 32'(count), 32'd0);
    chk({tag, ".rd_empty"}, 32'(rd_empty), 32'd1);
    chk({tag, ".wr_full"}, 32'(wr_full), 32'd0);
    chk({tag, ".almost_empty"}, 32'(almost_empty), 32'd1);
    chk({tag, ".almost_full"}, 32'(almost_full), 32'd0);
    chk({tag, ".overflow"}, 32'(overflow), 32'd0);
    chk({tag, ".underflow"}, 32'(underflow), 32'd0);
    chk({tag, ".rd_data"}, 32'(rd_data), 32'd0);
  endtask

  // One read-accepting cycle; in FWFT mode the head is checked before the edge,
  // in standard mode the registered word is checked after it.
  task automatic pop_chk(input string tag, input logic [23:0] exp, input logic also_wr,
                         input logic [23:0] wdat);
    rd_en   = 1'b1;
    wr_en   = also_wr;
    wr_data = wdat;
`ifdef SYNC_FIFO_FWFT_EN
    chk(tag, 32'(rd_data), 32'(exp));
    tick();
`else
    tick();
    chk(tag, 32'(rd_data), 32'(exp));
`endif
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; wr_data = '0;
    tick(); tick();
    rst = 1'b0;
    tick();
    chk_reset_state("reset");

    // Fill 1..8, flags stepping with count
    for (int i = 1; i <= 8; i++) begin
      wr_en = 1'b1; wr_data = 24'(i);
      tick();
      $display("write 0x%06h count=%0d", wr_data, count);
      chk("fill.count", 32'(count), 32'(i));
      chk("fill.almost_empty", 32'(almost_empty), 32'(i <= 1));
      chk("fill.almost_full", 32'(almost_full), 32'(i >= 7));
      chk("fill.wr_full", 32'(wr_full), 32'(i == 8));
      chk("fill.rd_empty", 32'(rd_empty), 32'd0);
    end
    wr_data = 24'h9;
    tick();
    chk("ovf.pulse", 32'(overflow), 32'd1);
    chk("ovf.count", 32'(count), 32'd8);
    wr_en = 1'b0;
    tick();
    chk("ovf.clear", 32'(overflow), 32'd0);

    // Drain in order
    for (int k = 1; k <= 8; k++) begin
      pop_chk("drain.data", 24'(k), 1'b0, 24'h0);
      $display("read 0x%06h count=%0d", rd_data, count);
      chk("drain.count", 32'(count), 32'(8 - k));
    end
    chk("drain.rd_empty", 32'(rd_empty), 32'd1);
    chk("drain.almost_empty", 32'(almost_empty), 32'd1);
    rd_en = 1'b1;
    tick();
    chk("udf.pulse", 32'(underflow), 32'd1);
    chk("udf.count", 32'(count), 32'd0);
    rd_en = 1'b0;
    tick();
    chk("udf.clear", 32'(underflow), 32'd0);

    // Steady state at count=4 across two pointer wraps
    for (int i = 0; i < 4; i++) begin
      wr_en = 1'b1; wr_data = 24'h100 + 24'(i);
      tick();
    end
    wr_en = 1'b0;
    chk("stream.prefill", 32'(count), 32'd4);
    for (int i = 0; i < 20; i++) begin
      pop_chk("stream.data", 24'h100 + 24'(i), 1'b1, 24'h104 + 24'(i));
      $display("stream rd=0x%06h count=%0d", rd_data, count);
      chk("stream.count", 32'(count), 32'd4);
    end
    for (int i = 0; i < 4; i++) begin
      pop_chk("stream.tail", 24'h114 + 24'(i), 1'b0, 24'h0);
    end
    rd_en = 1'b0;
    chk("stream.empty", 32'(rd_empty), 32'd1);

    // Full plus simultaneous requests: read wins
    for (int i = 0; i < 8; i++) begin
      wr_en = 1'b1; wr_data = 24'h200 + 24'(i);
      tick();
    end
    chk("both_full.pre", 32'(wr_full), 32'd1);
    pop_chk("both_full.data", 24'h200, 1'b1, 24'hDEAD00);
    chk("both_full.count", 32'(count), 32'd7);
    chk("both_full.overflow", 32'(overflow), 32'd1);
    chk("both_full.wr_full", 32'(wr_full), 32'd0);
    for (int i = 1; i < 8; i++) begin
      pop_chk("both_full.drain", 24'h200 + 24'(i), 1'b0, 24'h0);
    end
    chk("both_full.empty", 32'(rd_empty), 32'd1);

    // Empty plus simultaneous requests: write wins, word read back next
    wr_en = 1'b1; rd_en = 1'b1; wr_data = 24'h300;
    tick();
    wr_en = 1'b0; rd_en = 1'b0;
    chk("both_empty.count", 32'(count), 32'd1);
    chk("both_empty.underflow", 32'(underflow), 32'd1);
    chk("both_empty.rd_empty", 32'(rd_empty), 32'd0);
    pop_chk("both_empty.data", 24'h300, 1'b0, 24'h0);
    rd_en = 1'b0;
    chk("both_empty.after", 32'(count), 32'd0);

    // Asynchronous reset mid-cycle with count=5
    for (int i = 0; i < 5; i++) begin
      wr_en = 1'b1; wr_data = 24'h400 + 24'(i);
      tick();
    end
    wr_en = 1'b0;
    chk("arst.pre", 32'(count), 32'd5);
    #1 rst = 1'b1;
    #1;
    chk_reset_state("arst");
    #1 rst = 1'b0;
    tick();
    wr_en = 1'b1; wr_data = 24'hABCDEF;
    tick();
    wr_en = 1'b0;
    chk("arst.write_count", 32'(count), 32'd1);
    pop_chk("arst.readback", 24'hABCDEF, 1'b0, 24'h0);
    rd_en = 1'b0;
    $display("readback 0x%06h count=%0d", rd_data, count);
    chk("arst.final_empty", 32'(rd_empty), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
